// File: rtl/lut_writer.sv
// Purpose: write side and storage of the decode LUT (4 types x 32 slots x DW bits), with a bulk-clear sweep.
// Latency: one write commits per clock and wr_done/wr_err pulse the cycle after; rd_data is combinational.
// Backpressure: wr_ready is low during the 128-cycle clear sweep and while clr_req is asserted in IDLE.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   wr_valid/wr_ready  programming handshake; wr_type/wr_imm/wr_data carry the entry and value
//   wr_done/wr_err     one-cycle status pulse for the previous accepted write (committed / dropped)
//   clr_req            level request for a full-table clear, sampled in IDLE
//   busy               clear sweep in progress
//   wr_count           committed writes since the last clear, saturating at 255
//   rd_type/rd_imm     decode-side lookup address; rd_data is the table value (0 if busy or type invalid)
module lut_writer #(
  parameter int DW     = 8,
  parameter int IMM_W  = 5,
  parameter int NTYPES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_type,
  input  logic [IMM_W-1:0] wr_imm,
  input  logic [DW-1:0]    wr_data,
  output logic             wr_done,
  output logic             wr_err,
  input  logic             clr_req,
  output logic             busy,
  output logic [7:0]       wr_count,
  input  logic [2:0]       rd_type,
  input  logic [IMM_W-1:0] rd_imm,
  output logic [DW-1:0]    rd_data
);

  // Entry address is {type[1:0], imm}; only the low two type bits index storage,
  // the type-range check keeps codes 4..7 from aliasing onto 0..3.
  localparam int TYPE_W = 2;
  localparam int AW     = TYPE_W + IMM_W;
  localparam int NENT   = 1 << AW;

  localparam logic [2:0]    NTYPES_C = 3'(NTYPES);
  localparam logic [AW-1:0] LAST_ENT = '1;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_ptr;
  logic [DW-1:0]   mem [NENT];

  logic            wr_fire;
  logic            wr_type_ok;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;

  assign busy       = (state == CLEAR);
  assign wr_ready   = (state == IDLE) && !clr_req;
  assign wr_fire    = wr_valid && wr_ready;
  assign wr_type_ok = (wr_type < NTYPES_C);
  assign wr_addr    = {wr_type[TYPE_W-1:0], wr_imm};
  assign rd_addr    = {rd_type[TYPE_W-1:0], rd_imm};

  // Storage is not touched by reset: the sweep that reset starts zeroes every
  // entry, and reset also suppresses any write presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      wr_done  <= 1'b0;
      wr_err   <= 1'b0;
      wr_count <= '0;
    end else begin
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      case (state)
        CLEAR: begin
          mem[clr_ptr] <= '0;
          clr_ptr      <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ENT) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            wr_count <= '0;
          end else if (wr_fire) begin
            if (wr_type_ok) begin
              mem[wr_addr] <= wr_data;
              wr_done      <= 1'b1;
              if (wr_count != 8'hFF) begin
                wr_count <= wr_count + 8'd1;
              end
            end else begin
              wr_err <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Decode reads the registered array directly, so a same-cycle write to the
  // addressed entry becomes visible only from the following cycle.
  always_comb begin
    rd_data = '0;
    if (!busy && (rd_type < NTYPES_C)) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_lut_writer.sv
// Purpose: scoreboard bench for lut_writer; writes are modelled as a plain 4x32 byte array plus a saturating count.
// Latency: expected done/err pulses are queued with the cycle they are due and checked by a separate monitor.
// Backpressure: expected readiness comes from the bench's own knowledge of when a sweep is running.
module tb_lut_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_type = '0;
  logic [4:0] wr_imm = '0;
  logic [7:0] wr_data = '0;
  logic       wr_done;
  logic       wr_err;
  logic       clr_req = 1'b0;
  logic       busy;
  logic [7:0] wr_count;
  logic [2:0] rd_type = '0;
  logic [4:0] rd_imm = '0;
  logic [7:0] rd_data;

  lut_writer #(.DW(8), .IMM_W(5), .NTYPES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_type  (wr_type),
    .wr_imm   (wr_imm),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .wr_err   (wr_err),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_count (wr_count),
    .rd_type  (rd_type),
    .rd_imm   (rd_imm),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: table contents and committed-write count.
  logic [7:0] mmem [4][32];
  int         mcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mread(input logic [2:0] t, input logic [4:0] i);
    if (t < 3'd4) return mmem[t[1:0]][i];
    return 8'h00;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 32; i++)
        mmem[t][i] = 8'h00;
    mcount = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n cycles of sweep; when full, also confirm the block is idle afterwards.
  task automatic wait_sweep(input int n, input bit full);
    for (int k = 0; k < n; k++) begin
      rd_type = 3'($urandom_range(0, 3));
      rd_imm  = 5'($urandom);
      #4;
      chk("sweep_busy", busy, 1);
      chk("sweep_ready", wr_ready, 0);
      chk("sweep_rd", rd_data, 0);
      tick();
    end
    if (full) begin
      #4;
      chk("idle_busy", busy, 0);
      chk("idle_ready", wr_ready, 1);
      tick();
    end
  endtask

  task automatic chk_count();
    #4;
    chk("wr_count", wr_count, mcount);
    tick();
  endtask

  task automatic read_all();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 32; i++) begin
        rd_type = (t == 4) ? 3'd5 : 3'(t);
        rd_imm  = 5'(i);
        #4;
        chk("rd_table", rd_data, mread(rd_type, rd_imm));
        tick();
      end
    end
  endtask

  task automatic wr(input logic [2:0] t, input logic [4:0] i, input logic [7:0] d);
    exp_t e;
    wr_valid = 1'b1;
    wr_type  = t;
    wr_imm   = i;
    wr_data  = d;
    e.is_err = (t >= 3'd4);
    e.due    = cyc + 1;
    q.push_back(e);
    #4;
    chk("wr_ready", wr_ready, 1);
    chk("wr_count", wr_count, mcount);
    chk("rd_before_edge", rd_data, mread(rd_type, rd_imm));
    tick();
    if (t < 3'd4) begin
      mmem[t[1:0]][i] = d;
      if (mcount < 255) mcount++;
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("status_done", wr_done, e.is_err ? 0 : 1);
          chk("status_err", wr_err, e.is_err ? 1 : 0);
        end else if (wr_done === 1'b1 || wr_err === 1'b1) begin
          chk("unexpected_pulse", {wr_done, wr_err}, 0);
        end
      end
    join_none

    // Power-up reset and first sweep.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    wait_sweep(128, 1);
    read_all();
    chk_count();

    // Back-to-back programming writes.
    rd_type = 3'd1;
    rd_imm  = 5'd0;
    for (int k = 0; k < 8; k++) wr(3'd0, 5'(k), 8'(k + 1));
    wr(3'd1, 5'd0, 8'd176);
    wr(3'd1, 5'd1, 8'd7);
    wr(3'd2, 5'd0, 8'd99);
    chk_count();
    read_all();

    // Invalid type is dropped with an error pulse.
    wr(3'd5, 5'd3, 8'hAA);
    chk_count();
    read_all();

    // Read and write the same entry in one cycle.
    rd_type = 3'd2;
    rd_imm  = 5'd0;
    wr(3'd2, 5'd0, 8'h55);
    #4;
    chk("rd_after_edge", rd_data, 8'h55);
    tick();

    // Random writes, including invalid types and idle gaps.
    for (int k = 0; k < 60; k++) begin
      rd_type = 3'($urandom_range(0, 7));
      rd_imm  = 5'($urandom);
      wr(3'($urandom_range(0, 7)), 5'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    chk_count();
    read_all();

    // Clear request beats a concurrent write.
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_type  = 3'd0;
    wr_imm   = 5'd4;
    wr_data  = 8'hEE;
    #4;
    chk("clr_ready", wr_ready, 0);
    chk("clr_busy", busy, 0);
    tick();
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    model_clear();
    wait_sweep(128, 1);
    chk_count();
    read_all();

    // Reset in the middle of a sweep restarts it from entry 0.
    wr(3'd3, 5'd9, 8'h3C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    wait_sweep(60, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_sweep(128, 1);
    chk_count();

    // Reset on the same edge as a handshake: no write and no status pulse.
    wr_valid = 1'b1;
    wr_type  = 3'd1;
    wr_imm   = 5'd2;
    wr_data  = 8'h09;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    wr_valid = 1'b0;
    model_clear();
    wait_sweep(128, 1);
    chk_count();

    // Count saturation.
    for (int k = 0; k < 300; k++)
      wr(3'($urandom_range(0, 3)), 5'($urandom), 8'($urandom));
    chk_count();
    chk("count_saturated", wr_count, 255);
    read_all();

    tick();
    tick();
    chk("pending_status", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
